mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit that executes the M-extension codes on the 5-bit ALUCtrl bus produced by instruction decode.
- Sits beside the single-cycle ALU in EX. It accepts one operation, holds the pipeline busy while computing, then returns the result with a one-cycle done pulse.
- Uses a radix-2 shift-add multiplier and a restoring divider with sign pre/post correction.

Parameters:
- BITS, 32, operand/result width.
- CNT_W, $clog2(BITS)+1, iteration counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid_i  input  1  request valid; accepted only when ready_o=1.
- ALUCtrl  input  5  operation code from `alu_control_def.v`.
- op_a  input  BITS  rs1 value (multiplicand/dividend).
- op_b  input  BITS  rs2 value (multiplier/divisor).
- flush_i  input  1  synchronous abort (branch flush).
- ready_o  output  1  unit idle, can accept.
- busy_o  output  1  stall request to pipeline.
- done_o  output  1  one-cycle result-valid pulse.
- result_o  output  BITS  result; held until the next accept.

Behaviour:
- Reset: async to IDLE. ready_o=1, busy_o=0, done_o=0, result_o=0, counter=0.
- Accept: at a rising edge with valid_i && ready_o && code in {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU}. Operands and code are latched.
- Any other code with valid_i is ignored: no state change, no done.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - ready_o=1.
  - On accept: take absolute values per signedness, set counter=BITS, go to CALC.
  - MULHSU treats op_a as signed and op_b as unsigned.
- CALC:
  - One bit per cycle; counter decrements.
  - Multiply: 2*BITS-bit product accumulator.
  - Divide: restoring subtract-shift producing quotient and remainder.
  - Go to FIX when counter reaches 1 on that edge, so exactly BITS CALC cycles.
- FIX:
  - Negate the product if operand signs differ (signed ops).
  - Quotient sign = sign(a) xor sign(b). Remainder sign = sign(a).
  - Select low half (MUL), high half (MULH*), quotient, or remainder.
  - Register into result_o. Go to DONE.
- DONE: done_o=1 for exactly one cycle, ready_o=0, then IDLE.
- Latency: done_o is high in the (BITS+2)th cycle after the accept edge (34 for BITS=32).
- Back-to-back: a new accept is possible in the cycle after DONE.
- ready_o=0 and busy_o=1 in CALC and FIX. busy_o=0 in DONE and IDLE. valid_i during busy is ignored; the pipeline holds it.
- Division by zero (architectural results):
  - DIV/DIVU give all ones.
  - REM/REMU give op_a.
- Signed overflow (op_a = most negative, op_b = -1):
  - DIV gives op_a.
  - REM gives 0.
- Special-case timing without the optional feature: both division cases above are flagged at accept, run the full latency, and FIX substitutes the architectural value.
- flush_i:
  - In CALC or FIX: go to IDLE next edge, no done, result_o unchanged.
  - In DONE: done still pulses.
  - In IDLE: no effect, and it blocks accept in that cycle.
- Reset mid-operation: immediate IDLE with reset values, no done.

Optional Feature:
- Macro: MDU_FAST_SPECIAL_EN.
- Defined: the following go IDLE -> DONE directly, with done_o in the cycle after accept (latency 1) and the same architectural results:
  - divide-by-zero;
  - signed overflow;
  - multiply with either operand zero (result 0).
- Not defined: every accepted operation takes the full BITS+2 latency; results are identical.

Decomposition:
- Shared header `alu_control_def.v`: ALUCtrl code constants (existing).
- Shared header `mdu_def.v`:
  - state encodings MDU_IDLE, MDU_CALC, MDU_FIX, MDU_DONE;
  - MDU_OP_W.
- Sub-module mdu_opdecode (combinational): ALUCtrl -> {is_mdu, is_div, want_high, want_rem, a_signed, b_signed}.

Test Plan:
- MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done_o exactly 34 cycles after accept, busy_o high for 32+1 cycles.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide/remainder:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Divide by zero: DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100. Latency 34 without MDU_FAST_SPECIAL_EN, 1 with it.
- Abort and reset:
  - flush_i at cycle 10 of DIV -> no done_o, ready_o high the next cycle, result_o keeps its prior value.
  - rst_n low mid-MUL -> all outputs at reset values immediately.
- Non-M code (ADD) with valid_i -> no state change. valid_i held during busy -> single done_o, then re-accept only after DONE.

Source files
------------

// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// ALUCtrl operation codes, controller states and the decoded-operation record.
package mdu_iter_pkg;

    localparam int MDU_OP_W = 5;

    localparam logic [MDU_OP_W-1:0] ALU_ADD    = 5'b00000;
    localparam logic [MDU_OP_W-1:0] ALU_SUB    = 5'b00001;
    localparam logic [MDU_OP_W-1:0] ALU_MUL    = 5'b10000;
    localparam logic [MDU_OP_W-1:0] ALU_MULH   = 5'b10001;
    localparam logic [MDU_OP_W-1:0] ALU_MULHSU = 5'b10010;
    localparam logic [MDU_OP_W-1:0] ALU_MULHU  = 5'b10011;
    localparam logic [MDU_OP_W-1:0] ALU_DIV    = 5'b10100;
    localparam logic [MDU_OP_W-1:0] ALU_DIVU   = 5'b10101;
    localparam logic [MDU_OP_W-1:0] ALU_REM    = 5'b10110;
    localparam logic [MDU_OP_W-1:0] ALU_REMU   = 5'b10111;

    typedef enum logic [1:0] {
        MDU_IDLE,
        MDU_CALC,
        MDU_FIX,
        MDU_DONE
    } mdu_state_t;

    typedef struct packed {
        logic is_mdu;
        logic is_div;
        logic want_high;
        logic want_rem;
        logic a_signed;
        logic b_signed;
    } mdu_dec_t;

endpackage

// File: rtl/mdu_iter_opdecode.sv
// Combinational ALUCtrl decoder: classifies an M-extension code into
// operation kind, result selection and operand signedness.
module mdu_opdecode
    import mdu_iter_pkg::*;
(
    input  logic [MDU_OP_W-1:0] ALUCtrl,
    output mdu_dec_t            dec
);

    always_comb begin
        dec = '0;
        unique case (ALUCtrl)
            ALU_MUL:    dec = '{is_mdu: 1'b1, is_div: 1'b0, want_high: 1'b0, want_rem: 1'b0, a_signed: 1'b1, b_signed: 1'b1};
            ALU_MULH:   dec = '{is_mdu: 1'b1, is_div: 1'b0, want_high: 1'b1, want_rem: 1'b0, a_signed: 1'b1, b_signed: 1'b1};
            ALU_MULHSU: dec = '{is_mdu: 1'b1, is_div: 1'b0, want_high: 1'b1, want_rem: 1'b0, a_signed: 1'b1, b_signed: 1'b0};
            ALU_MULHU:  dec = '{is_mdu: 1'b1, is_div: 1'b0, want_high: 1'b1, want_rem: 1'b0, a_signed: 1'b0, b_signed: 1'b0};
            ALU_DIV:    dec = '{is_mdu: 1'b1, is_div: 1'b1, want_high: 1'b0, want_rem: 1'b0, a_signed: 1'b1, b_signed: 1'b1};
            ALU_DIVU:   dec = '{is_mdu: 1'b1, is_div: 1'b1, want_high: 1'b0, want_rem: 1'b0, a_signed: 1'b0, b_signed: 1'b0};
            ALU_REM:    dec = '{is_mdu: 1'b1, is_div: 1'b1, want_high: 1'b0, want_rem: 1'b1, a_signed: 1'b1, b_signed: 1'b1};
            ALU_REMU:   dec = '{is_mdu: 1'b1, is_div: 1'b1, want_high: 1'b0, want_rem: 1'b1, a_signed: 1'b0, b_signed: 1'b0};
            default:    dec = '0;
        endcase
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M unit: radix-2 shift-add multiply / restoring divide on magnitudes.
// Define MDU_FAST_SPECIAL_EN to retire divide-by-zero, overflow and zero multiplies in one cycle.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int BITS  = 32,
    parameter int CNT_W = $clog2(BITS) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_i,
    input  logic [MDU_OP_W-1:0] ALUCtrl,
    input  logic [BITS-1:0]     op_a,
    input  logic [BITS-1:0]     op_b,
    input  logic                flush_i,
    output logic                ready_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [BITS-1:0]     result_o
);

    localparam logic [BITS-1:0] MOST_NEG = {1'b1, {(BITS-1){1'b0}}};

    mdu_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [BITS-1:0]  acc_hi, acc_lo, mcand, spec_val;
    logic             is_div_q, want_high_q, want_rem_q, neg_res_q, neg_rem_q, special_q;

    mdu_dec_t         dec;
    logic             a_neg, b_neg, div_zero, div_ovf, accept;
    logic [BITS-1:0]  a_mag, b_mag, spec_val_d;
    logic [BITS:0]    mul_sum, div_shift, div_trial;
    logic [BITS-1:0]  hi_nxt, lo_nxt;
    logic [2*BITS-1:0] prod, prod_fix;
    logic [BITS-1:0]  quo_fix, rem_fix, fix_result;

    mdu_opdecode u_dec (
        .ALUCtrl (ALUCtrl),
        .dec     (dec)
    );

    always_comb begin
        a_neg    = dec.a_signed & op_a[BITS-1];
        b_neg    = dec.b_signed & op_b[BITS-1];
        a_mag    = a_neg ? -op_a : op_a;
        b_mag    = b_neg ? -op_b : op_b;
        div_zero = dec.is_div && (op_b == '0);
        div_ovf  = dec.is_div && dec.a_signed && (op_a == MOST_NEG) && (op_b == '1);
        accept   = (state == MDU_IDLE) && valid_i && ready_o && !flush_i && dec.is_mdu;
        // Zero multiplies fall through to '0, which only the fast path consumes.
        if (div_zero)
            spec_val_d = dec.want_rem ? op_a : '1;
        else if (div_ovf)
            spec_val_d = dec.want_rem ? '0 : op_a;
        else
            spec_val_d = '0;
    end

`ifdef MDU_FAST_SPECIAL_EN
    logic fast_special;
    assign fast_special = div_zero || div_ovf ||
                          (!dec.is_div && ((op_a == '0) || (op_b == '0)));
`endif

    // acc_hi/acc_lo double as product halves (multiply) or remainder/quotient (divide).
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? mcand : '0)};
        div_shift = {acc_hi, acc_lo[BITS-1]};
        div_trial = div_shift - {1'b0, mcand};
        if (is_div_q) begin
            if (!div_trial[BITS]) begin
                hi_nxt = div_trial[BITS-1:0];
                lo_nxt = {acc_lo[BITS-2:0], 1'b1};
            end else begin
                hi_nxt = div_shift[BITS-1:0];
                lo_nxt = {acc_lo[BITS-2:0], 1'b0};
            end
        end else begin
            hi_nxt = mul_sum[BITS:1];
            lo_nxt = {mul_sum[0], acc_lo[BITS-1:1]};
        end
    end

    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_res_q ? -prod : prod;
        quo_fix  = neg_res_q ? -acc_lo : acc_lo;
        rem_fix  = neg_rem_q ? -acc_hi : acc_hi;
        if (special_q)
            fix_result = spec_val;
        else if (is_div_q)
            fix_result = want_rem_q ? rem_fix : quo_fix;
        else
            fix_result = want_high_q ? prod_fix[2*BITS-1:BITS] : prod_fix[BITS-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MDU_IDLE;
            cnt         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            mcand       <= '0;
            spec_val    <= '0;
            is_div_q    <= 1'b0;
            want_high_q <= 1'b0;
            want_rem_q  <= 1'b0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            special_q   <= 1'b0;
            ready_o     <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            result_o    <= '0;
        end else begin
            unique case (state)
                MDU_IDLE: begin
                    if (accept) begin
                        is_div_q    <= dec.is_div;
                        want_high_q <= dec.want_high;
                        want_rem_q  <= dec.want_rem;
                        neg_res_q   <= a_neg ^ b_neg;
                        neg_rem_q   <= a_neg;
                        special_q   <= div_zero || div_ovf;
                        spec_val    <= spec_val_d;
                        acc_hi      <= '0;
                        acc_lo      <= dec.is_div ? a_mag : b_mag;
                        mcand       <= dec.is_div ? b_mag : a_mag;
                        ready_o     <= 1'b0;
`ifdef MDU_FAST_SPECIAL_EN
                        if (fast_special) begin
                            state    <= MDU_DONE;
                            result_o <= spec_val_d;
                            done_o   <= 1'b1;
                        end else
`endif
                        begin
                            state  <= MDU_CALC;
                            cnt    <= CNT_W'(BITS);
                            busy_o <= 1'b1;
                        end
                    end
                end
                MDU_CALC: begin
                    if (flush_i) begin
                        state   <= MDU_IDLE;
                        ready_o <= 1'b1;
                        busy_o  <= 1'b0;
                    end else begin
                        acc_hi <= hi_nxt;
                        acc_lo <= lo_nxt;
                        cnt    <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1))
                            state <= MDU_FIX;
                    end
                end
                MDU_FIX: begin
                    if (flush_i) begin
                        state   <= MDU_IDLE;
                        ready_o <= 1'b1;
                        busy_o  <= 1'b0;
                    end else begin
                        result_o <= fix_result;
                        state    <= MDU_DONE;
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                    end
                end
                MDU_DONE: begin
                    state   <= MDU_IDLE;
                    done_o  <= 1'b0;
                    ready_o <= 1'b1;
                end
                default: begin
                    state   <= MDU_IDLE;
                    ready_o <= 1'b1;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: 64-bit arithmetic reference model, queued
// expectations popped by a done_o monitor, plus flush/reset/ignore scenarios.
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    localparam int BITS = 32;
    localparam logic [31:0] MOST_NEG = 32'h8000_0000;
`ifdef MDU_FAST_SPECIAL_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [4:0]  ALUCtrl = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        ready_o, busy_o, done_o;
    logic [31:0] result_o;

    mdu_iter #(.BITS(BITS), .CNT_W($clog2(BITS) + 1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (valid_i),
        .ALUCtrl  (ALUCtrl),
        .op_a     (op_a),
        .op_b     (op_b),
        .flush_i  (flush_i),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int unsigned acc;
        int unsigned lat;
        logic [4:0]  code;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    int          dones = 0;
    int          pushes = 0;
    logic [31:0] last_exp = '0;

    logic [4:0] m_codes [8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                                ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ua = longint'({32'b0, a});
        longint      ub = longint'({32'b0, b});
        logic [63:0] p;
        case (code)
            ALU_MUL:    begin p = sa * sb; return p[31:0];  end
            ALU_MULH:   begin p = sa * sb; return p[63:32]; end
            ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
            ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
            ALU_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MOST_NEG && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REM: begin
                if (b == 0) return a;
                if (a == MOST_NEG && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            ALU_REMU: return (b == 0) ? a : a % b;
            default:  return 32'h0;
        endcase
    endfunction

    function automatic int unsigned exp_lat(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
        bit div  = (code == ALU_DIV) || (code == ALU_DIVU) || (code == ALU_REM) || (code == ALU_REMU);
        bit sdiv = (code == ALU_DIV) || (code == ALU_REM);
        bit fast = div ? ((b == 0) || (sdiv && a == MOST_NEG && b == 32'hFFFF_FFFF))
                       : ((a == 0) || (b == 0));
        return (FAST_EN && fast) ? 1 : BITS + 2;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return MOST_NEG;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Holds valid_i for 'hold' cycles; every cycle the unit is ready counts as an accept.
    task automatic issue(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit push);
        int g = 0;
        while (!ready_o && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got ready_o=0 expected 1");
            return;
        end
        valid_i = 1'b1;
        ALUCtrl = code;
        op_a    = a;
        op_b    = b;
        for (int i = 0; i < hold; i++) begin
            if (ready_o && push && !flush_i) begin
                sb_q.push_back('{res: ref_model(code, a, b), acc: cyc + 1,
                                 lat: exp_lat(code, a, b), code: code});
                last_exp = ref_model(code, a, b);
                pushes++;
            end
            @(negedge clk);
        end
        valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((sb_q.size() != 0 || !ready_o) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got pending=%0d expected 0", sb_q.size());
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done_o) begin
            dones++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_o=1 expected no pending op");
            end else begin
                mon_e = sb_q.pop_front();
                check($sformatf("result_code%0h", mon_e.code), result_o, mon_e.res);
                check($sformatf("latency_code%0h", mon_e.code), 32'(cyc - mon_e.acc + 1), mon_e.lat);
            end
        end
    end

    logic [4:0]  d_code [13] = '{ALU_MULH, ALU_MULHU, ALU_MULHSU, ALU_DIV, ALU_REM,
                                 ALU_DIV, ALU_REM, ALU_DIVU, ALU_REMU, ALU_MUL,
                                 ALU_DIV, ALU_REM, ALU_MULHU};
    logic [31:0] d_a [13] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'h8000_0000, 32'h8000_0000, 32'd100, 32'd100, 32'h0,
                              32'd5, 32'hFFFF_FFF9, 32'h1234_5678};
    logic [31:0] d_b [13] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd5,
                              32'd0, 32'd0, 32'h0};

    initial begin
        int nb;
        int d0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_result", result_o, 32'h0);

        issue(ALU_MUL, 32'd7, 32'hFFFF_FFFD, 1, 1'b1);
        nb = 0;
        for (int i = 0; i < 60 && !done_o; i++) begin
            if (busy_o) nb++;
            @(negedge clk);
        end
        check("mul_busy_cycles", 32'(nb), 32'd33);
        check("done_ready_low", 32'(ready_o), 32'd0);
        wait_idle();

        for (int i = 0; i < 13; i++) begin
            issue(d_code[i], d_a[i], d_b[i], 1, 1'b1);
            wait_idle();
        end

        for (int i = 0; i < 40; i++) begin
            issue(m_codes[$urandom_range(0, 7)], pick_operand(), pick_operand(), 1, 1'b1);
            if ($urandom_range(0, 1) == 0) wait_idle();
        end
        wait_idle();

        // Non-M code is ignored.
        issue(ALU_ADD, 32'd1, 32'd2, 1, 1'b0);
        check("add_ready", 32'(ready_o), 32'd1);
        check("add_busy", 32'(busy_o), 32'd0);
        repeat (5) @(negedge clk);
        check("add_result", result_o, last_exp);

        // Flush while idle blocks the accept.
        flush_i = 1'b1;
        issue(ALU_DIV, 32'd1000, 32'd7, 1, 1'b0);
        flush_i = 1'b0;
        check("idleflush_ready", 32'(ready_o), 32'd1);
        check("idleflush_busy", 32'(busy_o), 32'd0);

        // Flush mid-divide.
        d0 = dones;
        issue(ALU_DIV, 32'd1000, 32'd7, 1, 1'b0);
        repeat (8) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_ready", 32'(ready_o), 32'd1);
        check("flush_busy", 32'(busy_o), 32'd0);
        check("flush_result", result_o, last_exp);
        repeat (40) @(negedge clk);
        check("flush_no_done", 32'(dones), 32'(d0));

        // valid_i held across the whole operation.
        d0 = dones;
        issue(ALU_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 36, 1'b1);
        wait_idle();
        check("held_valid_dones", 32'(dones - d0), 32'd2);

        // Reset mid-multiply.
        d0 = dones;
        issue(ALU_MUL, 32'd3, 32'd5, 1, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(ready_o), 32'd1);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_done", 32'(done_o), 32'd0);
        check("midrst_result", result_o, 32'h0);
        last_exp = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_no_done", 32'(dones), 32'(d0));
        issue(ALU_REM, 32'hFFFF_FF00, 32'd7, 1, 1'b1);
        wait_idle();

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(sb_q.size()), 32'd0);
        check("done_count", 32'(dones), 32'(pushes));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
